present_dec_core: RTL and testbench
===================================

// Module: present_dec_core
// PURPOSE
//  Round-based, area-optimised PRESENT-80 decryption core. It is the inverse datapath of the encryption core.
//  Per round it applies the inverse pLayer, then the inverse S-box, then the round-key XOR.
//  It first runs the forward key schedule to reach K32, then unwinds the schedule on the fly during decryption.
//  It sits beside the encryption core and uses the same valid/ready handshake on both sides.
// PARAMETERS
//  ROUNDS  31  Number of round-key updates. Must be 31 for standard PRESENT; smaller values are for debug only.
// PORTS
//  clk        in   1   Clock. Single clock domain.
//  rst        in   1   Reset. Synchronous, active-high.
//  in_valid   in   1   ct and key are valid.
//  in_ready   out  1   Core can accept a block. High only in IDLE.
//  ct         in   64  Ciphertext.
//  key        in   80  Cipher key; key[79] is the MSB.
//  out_valid  out  1   pt is valid. Held until it is accepted.
//  out_ready  in   1   Downstream accepts pt.
//  pt         out  64  Plaintext. Registered; stable while out_valid is high.
// BEHAVIOUR
//  Reset: FSM=IDLE; in_ready=0 in the reset cycle and 1 afterwards; out_valid=0; pt/state=0; key_reg=0; cnt=0.
//  Key update (fwd, counter i): k = k rotated left by 61; k[79:76]=S(k[79:76]); k[19:15]^=i[4:0].
//  Key update (inv, counter i): k[19:15]^=i[4:0]; k[79:76]=S^-1(k[79:76]); k = k rotated right by 61.
//  Round key = k[79:16].
//  S-box     = C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2.
//  S-box^-1  = 5,E,F,8,C,1,2,D,B,4,6,3,0,7,9,A.
//  Inverse pLayer: out[i]=in[(16*i) mod 63] for i=0..62; out[63]=in[63].
//  FSM IDLE:
//   - On in_valid&&in_ready: state<=ct; key_reg<=key; cnt<=1; go to KEYEXP.
//  FSM KEYEXP (ROUNDS cycles):
//   - Each cycle: key_reg<=fwd(key_reg,cnt).
//   - If cnt!=ROUNDS: cnt<=cnt+1.
//   - If cnt==ROUNDS: state<=state^fwd(key_reg,cnt)[79:16] (whitening with K32); cnt stays ROUNDS; go to DEC.
//  FSM DEC (ROUNDS cycles):
//   - Each cycle: nk=inv(key_reg,cnt); key_reg<=nk; state<=Sinv(Pinv(state))^nk[79:16].
//   - cnt<=cnt-1.
//   - When cnt==1: pt<=next state; out_valid<=1; go to DONE.
//  FSM DONE:
//   - Hold pt and out_valid.
//   - On out_ready: out_valid<=0; go to IDLE.
//   - in_ready goes high the following cycle. No same-cycle turnaround.
//  Latency: out_valid rises 2*ROUNDS (=62) clock edges after the accepting edge. Throughput is 1 block per 64 cycles minimum.
//  Busy: in_valid outside IDLE is ignored. ct/key are sampled only on the accepting edge and may change afterwards.
//  out_ready while out_valid=0 is ignored.
//  Reset mid-operation: abort immediately to the reset values. No partial pt is ever presented.
//  Width rules: cnt is 5 bits; i uses only its low 5 bits; all XORs are bitwise and carry-free.
//  key_reg after DEC equals the original key. The bench checks this as an internal assertion.
// STRUCTURE
//  present_pkg:
//   - SBOX and INV_SBOX 16x4 constant tables.
//   - ROUNDS_STD=31.
//   - FSM state encoding: IDLE, KEYEXP, DEC, DONE.
//   - Functions key_fwd() and key_inv().
//  Sub-module present_inv_pdata:
//   - Purely combinational 64-bit inverse bit permutation.
//   - Instantiated once on the state path.
//  Inverse S-box layer: 16 parallel lookups, inline in the core.
//  One 64-bit state register, one 80-bit key register, one 5-bit counter, 2-bit FSM.
// TESTING
//  1. key=0, ct=64'h5579C1387B228445 -> pt=0; out_valid exactly 62 edges after accept.
//  2. key=80'hFFFF_FFFFFFFF_FFFFFFFF, ct=64'hE72C46C0F5945049 -> pt=0.
//  3. key=0, ct=64'hA112FFC72F68417B -> pt=64'hFFFFFFFFFFFFFFFF.
//     Then key=all-ones, ct=64'h3333DCD3213210D2 -> pt=all-ones.
//  4. out_ready held low for 20 cycles:
//     - pt and out_valid stay stable and in_ready stays 0.
//     - A new in_valid pulse during DEC is ignored.
//     - After out_ready, in_ready=1 on the next cycle.
//  5. Assert rst at DEC cnt=15 -> next cycle out_valid=0, in_ready=0, pt=0.
//     Then in_ready=1; a fresh block (test 1 vector) decrypts correctly.
//  6. Back-to-back: in_valid held high and out_ready=1 for 4 random key/ct pairs.
//     - Each pt matches the golden encrypt-model inverse.
//     - Spacing between out_valid pulses is exactly 64 cycles.

Source files
------------

// File: rtl/present_pkg.sv
// Shared PRESENT-80 constants, FSM encoding and the key-schedule step functions.
// Used by the decryption core and its permutation sub-module.
package present_pkg;

  localparam int ROUNDS_STD = 31;

  localparam logic [3:0] SBOX [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  localparam logic [3:0] INV_SBOX [16] = '{
    4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
    4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    KEYEXP = 2'd1,
    DEC    = 2'd2,
    DONE   = 2'd3
  } fsm_t;

  // One forward schedule step: rotate left 61, S-box the top nibble, mix in the round counter.
  function automatic logic [79:0] key_fwd(input logic [79:0] k, input logic [4:0] i);
    logic [79:0] r;
    r          = {k[18:0], k[79:19]};
    r[79:76]   = SBOX[r[79:76]];
    r[19:15]   = r[19:15] ^ i;
    return r;
  endfunction

  // Exact inverse of key_fwd for the same counter value.
  function automatic logic [79:0] key_inv(input logic [79:0] k, input logic [4:0] i);
    logic [79:0] r;
    r          = k;
    r[19:15]   = r[19:15] ^ i;
    r[79:76]   = INV_SBOX[r[79:76]];
    return {r[60:0], r[79:61]};
  endfunction

endpackage

// File: rtl/present_inv_pdata.sv
// Inverse PRESENT pLayer: out[i] = in[(16*i) mod 63], bit 63 passes straight through.
// Pure wiring, no logic.
module present_inv_pdata
  import present_pkg::*;
(
  input  logic [63:0] din,
  output logic [63:0] dout
);

  for (genvar g = 0; g < 63; g++) begin : g_perm
    assign dout[g] = din[(16 * g) % 63];
  end

  assign dout[63] = din[63];

endmodule

// File: rtl/present_dec_core.sv
// Round-based PRESENT-80 decryption core: expands the key forward to K32, then
// unwinds it one step per round while applying inverse pLayer, inverse S-box and key XOR.
//
// state  | meaning
// IDLE   | waiting for a block, in_ready high (from the second cycle after reset)
// KEYEXP | running the forward schedule up to K32, whitening on the last step
// DEC    | one decryption round per cycle, key schedule unwound on the fly
// DONE   | plaintext held on pt with out_valid until out_ready
module present_dec_core
  import present_pkg::*;
#(
  parameter int ROUNDS = ROUNDS_STD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] ct,
  input  logic [79:0] key,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] pt
);

  localparam logic [4:0] LAST_CNT = 5'(ROUNDS);

  fsm_t        fsm;
  logic [63:0] state;
  logic [79:0] key_reg;
  logic [4:0]  cnt;

  logic [79:0] fwd_key;
  logic [79:0] inv_key;
  logic [63:0] pinv_out;
  logic [63:0] sinv_out;
  logic [63:0] dec_next;

  assign fwd_key = key_fwd(key_reg, cnt);
  assign inv_key = key_inv(key_reg, cnt);

  present_inv_pdata u_inv_pdata (
    .din  (state),
    .dout (pinv_out)
  );

  for (genvar n = 0; n < 16; n++) begin : g_sinv
    assign sinv_out[4*n +: 4] = INV_SBOX[pinv_out[4*n +: 4]];
  end

  // The unwound key is used in the same cycle it is produced, so round i XORs K_i.
  assign dec_next = sinv_out ^ inv_key[79:16];

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm       <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      pt        <= '0;
      state     <= '0;
      key_reg   <= '0;
      cnt       <= '0;
    end else begin
      case (fsm)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            state    <= ct;
            key_reg  <= key;
            cnt      <= 5'd1;
            in_ready <= 1'b0;
            fsm      <= KEYEXP;
          end
        end

        KEYEXP: begin
          key_reg <= fwd_key;
          if (cnt == LAST_CNT) begin
            state <= state ^ fwd_key[79:16];
            fsm   <= DEC;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end

        DEC: begin
          key_reg <= inv_key;
          state   <= dec_next;
          cnt     <= cnt - 5'd1;
          if (cnt == 5'd1) begin
            pt        <= dec_next;
            out_valid <= 1'b1;
            fsm       <= DONE;
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            fsm       <= IDLE;
          end
        end

        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_present_dec_core.sv
// Directed bench for present_dec_core: known PRESENT vectors, backpressure, reset abort
// and back-to-back blocks checked against a forward-encryption reference model.
module tb_present_dec_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] ct;
  logic [79:0] key;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] pt;

  typedef struct packed {
    logic [63:0] pt;
    logic [79:0] key;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  localparam logic [79:0] K0 = 80'h0;
  localparam logic [79:0] K1 = {80{1'b1}};
  localparam logic [63:0] P0 = 64'h0;
  localparam logic [63:0] P1 = {64{1'b1}};

  present_dec_core dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ct        (ct),
    .key       (key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pt        (pt)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] sb4(input logic [3:0] x);
    case (x)
      4'h0: return 4'hC;  4'h1: return 4'h5;  4'h2: return 4'h6;  4'h3: return 4'hB;
      4'h4: return 4'h9;  4'h5: return 4'h0;  4'h6: return 4'hA;  4'h7: return 4'hD;
      4'h8: return 4'h3;  4'h9: return 4'hE;  4'hA: return 4'hF;  4'hB: return 4'h8;
      4'hC: return 4'h4;  4'hD: return 4'h7;  4'hE: return 4'h1;  default: return 4'h2;
    endcase
  endfunction

  // Reference PRESENT-80 encryption; the bench decrypts its output through the DUT.
  function automatic logic [63:0] enc(input logic [63:0] p, input logic [79:0] k);
    logic [63:0] s;
    logic [63:0] t;
    logic [79:0] kk;
    s  = p;
    kk = k;
    for (int r = 1; r <= 31; r++) begin
      s = s ^ kk[79:16];
      for (int n = 0; n < 16; n++) t[4*n +: 4] = sb4(s[4*n +: 4]);
      for (int b = 0; b < 63; b++) s[(16 * b) % 63] = t[b];
      s[63]       = t[63];
      kk          = {kk[18:0], kk[79:19]};
      kk[79:76]   = sb4(kk[79:76]);
      kk[19:15]   = kk[19:15] ^ r[4:0];
    end
    return s ^ kk[79:16];
  endfunction

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input string tag, input logic [63:0] c, input logic [79:0] k,
                        input logic [63:0] exp_pt);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    if (!in_ready) check({tag, "_ready_timeout"}, 80'(in_ready), 80'd1);
    in_valid = 1'b1;
    ct       = c;
    key      = k;
    sb.push_back('{pt: exp_pt, key: k});
    tick();
    in_valid = 1'b0;
    ct       = {$urandom, $urandom};
    key      = {16'($urandom), $urandom, $urandom};
  endtask

  task automatic wait_result(input string tag, input bit chk_lat);
    int   n;
    exp_t e;
    n = 0;
    while (!out_valid && n < 200) begin
      tick();
      n++;
    end
    if (!out_valid) check({tag, "_out_timeout"}, 80'(out_valid), 80'd1);
    if (chk_lat) check({tag, "_latency"}, 80'(n), 80'd62);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 80'(sb.size()), 80'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_pt"}, 80'(pt), 80'(e.pt));
      check({tag, "_key_restored"}, dut.key_reg, e.key);
    end
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_out_valid_cleared"}, 80'(out_valid), 80'd0);
    check({tag, "_in_ready_back"}, 80'(in_ready), 80'd1);
  endtask

  initial begin
    logic [63:0] pts  [4];
    logic [79:0] keys [4];
    logic [63:0] cts  [4];
    int   j;
    int   got;
    int   cyc;
    int   last;
    bit   acc;
    exp_t e;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    ct        = '0;
    key       = '0;

    tick();
    check("rst_in_ready", 80'(in_ready), 80'd0);
    check("rst_out_valid", 80'(out_valid), 80'd0);
    check("rst_pt", 80'(pt), 80'd0);
    check("rst_key_reg", dut.key_reg, 80'd0);
    check("rst_cnt", 80'(dut.cnt), 80'd0);
    rst = 1'b0;
    tick();
    check("post_rst_in_ready", 80'(in_ready), 80'd1);

    accept("t1", 64'h5579C1387B228445, K0, P0);
    wait_result("t1", 1'b1);
    release_out("t1");

    accept("t2", 64'hE72C46C0F5945049, K1, P0);
    wait_result("t2", 1'b1);
    release_out("t2");

    accept("t3a", 64'hA112FFC72F68417B, K0, P1);
    wait_result("t3a", 1'b1);
    release_out("t3a");

    accept("t3b", 64'h3333DCD3213210D2, K1, P1);
    wait_result("t3b", 1'b1);
    release_out("t3b");

    // Backpressure with a stray in_valid pulse while decrypting.
    accept("t4", 64'hA112FFC72F68417B, K0, P1);
    repeat (40) tick();
    in_valid = 1'b1;
    ct       = 64'h0123456789ABCDEF;
    key      = 80'h1234_5678_9ABC_DEF0_1357;
    tick();
    in_valid = 1'b0;
    wait_result("t4", 1'b0);
    for (int c = 0; c < 20; c++) begin
      tick();
      check("t4_hold_out_valid", 80'(out_valid), 80'd1);
      check("t4_hold_pt", 80'(pt), 80'(P1));
      check("t4_hold_in_ready", 80'(in_ready), 80'd0);
    end
    release_out("t4");
    repeat (70) tick();
    check("t4_no_ghost_block", 80'(out_valid), 80'd0);
    check("t4_idle_ready", 80'(in_ready), 80'd1);

    // Reset abort in the middle of DEC.
    accept("t5", 64'h5579C1387B228445, K0, P0);
    repeat (47) tick();
    check("t5_cnt_before_rst", 80'(dut.cnt), 80'd15);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_abort_out_valid", 80'(out_valid), 80'd0);
    check("t5_abort_in_ready", 80'(in_ready), 80'd0);
    check("t5_abort_pt", 80'(pt), 80'd0);
    sb.delete();
    tick();
    check("t5_ready_after_rst", 80'(in_ready), 80'd1);
    accept("t5b", 64'h5579C1387B228445, K0, P0);
    wait_result("t5b", 1'b1);
    release_out("t5b");

    // Back-to-back random blocks with in_valid and out_ready held high.
    for (int i = 0; i < 4; i++) begin
      pts[i]  = {$urandom, $urandom};
      keys[i] = {16'($urandom), $urandom, $urandom};
      cts[i]  = enc(pts[i], keys[i]);
    end
    j         = 0;
    got       = 0;
    cyc       = 0;
    last      = 0;
    in_valid  = 1'b1;
    ct        = cts[0];
    key       = keys[0];
    out_ready = 1'b1;
    while (got < 4 && cyc < 2000) begin
      acc = in_valid && in_ready;
      if (acc) sb.push_back('{pt: pts[j], key: keys[j]});
      tick();
      cyc++;
      if (acc) begin
        j++;
        if (j < 4) begin
          ct  = cts[j];
          key = keys[j];
        end else begin
          in_valid = 1'b0;
        end
      end
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("t6_sb_empty", 80'(sb.size()), 80'd1);
        end else begin
          e = sb.pop_front();
          check("t6_pt", 80'(pt), 80'(e.pt));
          check("t6_key_restored", dut.key_reg, e.key);
        end
        if (got > 0) check("t6_spacing", 80'(cyc - last), 80'd64);
        last = cyc;
        got++;
      end
    end
    if (got < 4) check("t6_timeout", 80'(got), 80'd4);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("final_sb_drained", 80'(sb.size()), 80'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
